multicycle_control: RTL
=======================

# multicycle_control

Moore-style control FSM for the multi-cycle ARM-subset processor. It sequences fetch, decode, execute, memory and writeback over a shared ALU, memory port and register file. Each cycle it drives the enables and mux selects, including `imm_src_out`, which steers the immediate extender's `op_in` (00 data imm8, 01 memory imm12, 10 branch imm24). It also holds the NZCV flag register and evaluates condition codes, so that writes are suppressed when an instruction's condition fails.

## Interface
- No parameters.
- `clk_in`  in  1  rising-edge clock
- `reset_in`  in  1  asynchronous, active-high reset
- `op_in`  in  2  instruction [27:26]: 00 data, 01 memory, 10 branch, 11 undefined
- `funct_in`  in  6  instruction [25:20]: [5] I, [4:1] cmd, [0] S (data) / L (memory)
- `cond_in`  in  4  instruction [31:28]
- `rd_in`  in  4  instruction [15:12]
- `alu_flags_in`  in  4  NZCV from the ALU, current cycle
- `state_out`  out  4  current state encoding (below)
- `imm_src_out`  out  2  to extender `op_in`
- `reg_src_out`  out  2  [0] read R15 on port A (branch); [1] read Rd on port B (store)
- `pc_write_out`, `ir_write_out`, `reg_write_out`, `mem_write_out`  out  1 each  write enables
- `adr_src_out`  out  1  0 = PC, 1 = ALU result register
- `alu_src_a_out`  out  1  0 = register A, 1 = PC
- `alu_src_b_out`  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- `alu_control_out`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- `result_src_out`  out  2  00 ALU result register, 01 memory data, 10 ALU direct
- `flags_out`  out  4  registered NZCV

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9. Codes 10–15 return to FETCH on the next edge with all enables 0.
- Unlisted outputs in each state are 0.
- FETCH: `ir_write`=1, `pc_write`=1, `alu_src_a`=1, `alu_src_b`=10, ADD, `result_src`=10. Next state DECODE.
- DECODE: `alu_src_a`=1, `alu_src_b`=10, `result_src`=10. Next state by opcode:
  - op 01 → MEMADR
  - op 00 with I=0 → EXECUTER; with I=1 → EXECUTEI
  - op 10 → BRANCH
  - op 11 → FETCH, no writes
- MEMADR: `alu_src_b`=01, `imm_src`=01, ADD. Next state MEMREAD if L=1, else MEMWRITE.
- MEMREAD: `adr_src`=1. Next state MEMWB.
- MEMWB: `result_src`=01, `reg_write`=ok; `pc_write`=ok when `rd_in`=15. Next state FETCH.
- MEMWRITE: `adr_src`=1, `mem_write`=ok. Next state FETCH.
- EXECUTER: `alu_src_b`=00. EXECUTEI: `alu_src_b`=01, `imm_src`=00. Both go to ALUWB next.
- ALUWB: `result_src`=00, `reg_write`=ok·supported·not CMP; `pc_write` follows the same condition when `rd_in`=15. Next state FETCH.
- BRANCH: `alu_src_b`=01, `imm_src`=10, ADD, `result_src`=10, `pc_write`=ok. Next state FETCH.
- Command decode (EXECUTER, EXECUTEI and ALUWB):
  - `cmd` 0100 ADD → 00; 0010 SUB → 01; 0000 AND → 10; 1100 ORR → 11; 1010 CMP → 01.
  - Any other `cmd` is unsupported: ADD, no register or flag write.
- `reg_src_out` is combinational from `op_in` in every state: [0]=(op=10), [1]=(op=01 and L=0).
- Condition `ok` is evaluated from `flags_out`, never from `alu_flags_in`:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C·!Z; LS !C+Z; GE N=V; LT N≠V; GT !Z·(N=V); LE Z+(N≠V)
  - AL 1; 1111 0
- Flag update, on the edge leaving EXECUTER/EXECUTEI when S=1, ok=1 and `cmd` is supported:
  - N,Z always load from `alu_flags_in`.
  - C,V load only for ADD, SUB or CMP; otherwise they hold.

## Timing
- Reset: state FETCH and `flags_out`=0000, asynchronously.
- While `reset_in`=1, every write enable (`pc`, `ir`, `reg`, `mem`) is forced 0; other outputs hold their FETCH values.
- Reset deasserting mid-instruction abandons that instruction; the first edge after release is a FETCH.
- All outputs except `reg_src_out` are decoded from the state only (Moore).
- `op_in`, `funct_in`, `cond_in` and `rd_in` come from the IR and are stable from DECODE through writeback.
- Instruction latency, in cycles: branch 3, data processing 4, store 4, load 5, undefined 2.
- Flags written by an instruction affect only later instructions; the S-instruction's own writeback uses the old flags.

## Test plan
- Reset: assert `reset_in` mid-MEMREAD → `state_out`=0 immediately, all write enables 0, `flags_out`=0000. Release → FETCH then DECODE.
- ADDS register form (op 00, funct 001001, AL, rd 3), with `alu_flags_in`=0100:
  - States run 0, 1, 6, 8, 0.
  - `reg_write`=1 in ALUWB.
  - `flags_out`=0100 after EXECUTER.
- CMP then BEQ:
  - CMP with `alu_flags_in`=0110 → no `reg_write`, `flags_out`=0110.
  - BEQ (cond 0000) → BRANCH with `imm_src`=10, `pc_write`=1.
  - Repeat with Z=0 → `pc_write`=0 in BRANCH.
- LDR to R15 (op 01, L=1, rd 15):
  - States run 0, 1, 2, 3, 4, 0.
  - `imm_src`=01 in MEMADR; `adr_src`=1 in MEMREAD.
  - `reg_write`=1 and `pc_write`=1 in MEMWB.
- STRNE with Z=1 → MEMWRITE reached with `mem_write`=0; `reg_src_out`=10 throughout.
- op 11 → DECODE returns to FETCH with zero writes. Unsupported `cmd` 0001 with S=1 → no `reg_write`, flags unchanged.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle ARM-subset datapath. Sequences each instruction
// through fetch/decode/execute/memory/writeback, owns the NZCV flag register and
// gates every architectural write on the instruction's condition code.
module multicycle_control (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [1:0] op_in,
    input  logic [5:0] funct_in,
    input  logic [3:0] cond_in,
    input  logic [3:0] rd_in,
    input  logic [3:0] alu_flags_in,
    output logic [3:0] state_out,
    output logic [1:0] imm_src_out,
    output logic [1:0] reg_src_out,
    output logic       pc_write_out,
    output logic       ir_write_out,
    output logic       reg_write_out,
    output logic       mem_write_out,
    output logic       adr_src_out,
    output logic       alu_src_a_out,
    output logic [1:0] alu_src_b_out,
    output logic [1:0] alu_control_out,
    output logic [1:0] result_src_out,
    output logic [3:0] flags_out
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    // Condition result latched at execute so writeback sees the pre-update flags.
    logic       exec_ok_q, exec_ok_d;

    logic [3:0] cmd;
    logic       cond_ok, cmd_ok, cmd_cv, cmd_cmp, wb_ok;
    logic [1:0] cmd_ctrl;
    logic       pc_en, ir_en, reg_en, mem_en;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign cmd = funct_in[4:1];
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Condition code evaluation against the registered flags.
    always_comb begin
        cond_ok = 1'b0;
        case (cond_in)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Data-processing command decode: ALU op, C/V update and CMP detection.
    always_comb begin
        cmd_ok   = 1'b1;
        cmd_ctrl = 2'b00;
        cmd_cv   = 1'b0;
        cmd_cmp  = 1'b0;
        case (cmd)
            4'b0100: begin cmd_ctrl = 2'b00; cmd_cv = 1'b1; end
            4'b0010: begin cmd_ctrl = 2'b01; cmd_cv = 1'b1; end
            4'b0000: cmd_ctrl = 2'b10;
            4'b1100: cmd_ctrl = 2'b11;
            4'b1010: begin cmd_ctrl = 2'b01; cmd_cv = 1'b1; cmd_cmp = 1'b1; end
            default: cmd_ok = 1'b0;
        endcase
    end

    assign wb_ok = exec_ok_q && cmd_ok && !cmd_cmp;

    // State, flag and latched-condition registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            exec_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            exec_ok_q <= exec_ok_d;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_d         = StFetch;
        flags_d         = flags_q;
        exec_ok_d       = exec_ok_q;
        imm_src_out     = 2'b00;
        pc_en           = 1'b0;
        ir_en           = 1'b0;
        reg_en          = 1'b0;
        mem_en          = 1'b0;
        adr_src_out     = 1'b0;
        alu_src_a_out   = 1'b0;
        alu_src_b_out   = 2'b00;
        alu_control_out = 2'b00;
        result_src_out  = 2'b00;
        case (state_q)
            StFetch: begin
                ir_en          = 1'b1;
                pc_en          = 1'b1;
                alu_src_a_out  = 1'b1;
                alu_src_b_out  = 2'b10;
                result_src_out = 2'b10;
                state_d        = StDecode;
            end
            StDecode: begin
                alu_src_a_out  = 1'b1;
                alu_src_b_out  = 2'b10;
                result_src_out = 2'b10;
                case (op_in)
                    2'b00:   state_d = funct_in[5] ? StExecI : StExecR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                alu_src_b_out = 2'b01;
                imm_src_out   = 2'b01;
                state_d       = funct_in[0] ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src_out = 1'b1;
                state_d     = StMemWb;
            end
            StMemWb: begin
                result_src_out = 2'b01;
                reg_en         = cond_ok;
                pc_en          = cond_ok && (rd_in == 4'd15);
            end
            StMemWrite: begin
                adr_src_out = 1'b1;
                mem_en      = cond_ok;
            end
            StExecR, StExecI: begin
                alu_src_b_out   = (state_q == StExecI) ? 2'b01 : 2'b00;
                alu_control_out = cmd_ctrl;
                exec_ok_d       = cond_ok;
                if (funct_in[0] && cond_ok && cmd_ok) begin
                    flags_d[3:2] = alu_flags_in[3:2];
                    if (cmd_cv) flags_d[1:0] = alu_flags_in[1:0];
                end
                state_d = StAluWb;
            end
            StAluWb: begin
                alu_control_out = cmd_ctrl;
                reg_en          = wb_ok;
                pc_en           = wb_ok && (rd_in == 4'd15);
            end
            StBranch: begin
                alu_src_b_out  = 2'b01;
                imm_src_out    = 2'b10;
                result_src_out = 2'b10;
                pc_en          = cond_ok;
            end
            default: state_d = StFetch;
        endcase
    end

    // Write enables are held off for as long as reset is asserted.
    assign pc_write_out  = pc_en && !reset_in;
    assign ir_write_out  = ir_en && !reset_in;
    assign reg_write_out = reg_en && !reset_in;
    assign mem_write_out = mem_en && !reset_in;

    assign reg_src_out = {(op_in == 2'b01) && !funct_in[0], (op_in == 2'b10)};
    assign state_out   = state_q;
    assign flags_out   = flags_q;

endmodule
